// File: rtl/mfcc_frame_sequencer.sv
// rtl/mfcc_frame_sequencer.sv - packs indexed MFCC coefficients into frames for the DNN input layer
//
// Assembles NCOEF coefficients, arriving one per rising edge of dv and tagged
// with x_index, into a feature frame. Index order is checked, frames can be
// gated on voice activity, and finished frames go out through one holding slot
// with a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   dv           coefficient data-valid level (rising edge = one capture)
//   x_index      coefficient index, sampled with the capture
//   x_i          coefficient value, sampled with the capture
//   vad          voice-activity flag, sampled with the capture
//   frame_ready  consumer accepts the held frame
//   frame_valid  output slot holds a complete frame
//   frame_data   coefficient k at bits [k*W +: W]
//   drop_cnt     saturating count of frames lost to a full slot
//   resync_cnt   saturating count of index errors
//   collecting   registered decode of the COLLECT state
module mfcc_frame_sequencer #(
  parameter int NCOEF    = 12,
  parameter int W        = 32,
  parameter bit VAD_GATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dv,
  input  logic [4:0]           x_index,
  input  logic [W-1:0]         x_i,
  input  logic                 vad,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [NCOEF*W-1:0]   frame_data,
  output logic [7:0]           drop_cnt,
  output logic [7:0]           resync_cnt,
  output logic                 collecting
);

  localparam logic [4:0] LAST_IDX = 5'(NCOEF - 1);

  typedef enum logic {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 dv_d;
  logic [4:0]           exp_idx, exp_idx_d;
  logic                 vad_acc, vad_acc_d;
  logic [NCOEF*W-1:0]   asm_q;
  logic                 pend_q;

  logic                 capture;
  logic                 vad_now;
  logic                 wr_en;
  logic                 complete;
  logic                 resync_inc;
  logic                 pend_d;

  assign capture = dv & ~dv_d;
  assign vad_now = vad_acc | vad;

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx;
    vad_acc_d  = vad_acc;
    wr_en      = 1'b0;
    complete   = 1'b0;
    resync_inc = 1'b0;
    if (capture) begin
      case (state_q)
        SYNC: begin
          if (x_index == 5'd0) begin
            wr_en     = 1'b1;
            exp_idx_d = 5'd1;
            vad_acc_d = vad;
            state_d   = COLLECT;
          end
        end
        COLLECT: begin
          // exp_idx never exceeds LAST_IDX here, so an out-of-range index
          // can never match and always lands in the mismatch branch.
          if (x_index == exp_idx) begin
            wr_en     = 1'b1;
            vad_acc_d = vad_now;
            if (exp_idx == LAST_IDX) begin
              complete  = 1'b1;
              exp_idx_d = 5'd0;
              state_d   = SYNC;
            end else begin
              exp_idx_d = exp_idx + 5'd1;
            end
          end else begin
            resync_inc = 1'b1;
            if (x_index == 5'd0) begin
              wr_en     = 1'b1;
              exp_idx_d = 5'd1;
              vad_acc_d = vad;
            end else begin
              exp_idx_d = 5'd0;
              state_d   = SYNC;
            end
          end
        end
        default: begin
          exp_idx_d = 5'd0;
          state_d   = SYNC;
        end
      endcase
    end
  end

  // Only frames that will be offered to the slot are flagged; silent frames
  // under gating vanish here without touching any counter.
  assign pend_d = complete & (~VAD_GATE | vad_now);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      dv_d    <= 1'b0;
      exp_idx <= 5'd0;
      vad_acc <= 1'b0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_d    <= dv;
      exp_idx <= exp_idx_d;
      vad_acc <= vad_acc_d;
      pend_q  <= pend_d;
      for (int k = 0; k < NCOEF; k++) begin
        if (wr_en && (x_index == 5'(k))) begin
          asm_q[k*W +: W] <= x_i;
        end
      end
    end
  end

  // Transfer stage, one edge after completion. A capture needs dv low on the
  // preceding cycle, so no capture can land on the transfer edge and asm_q is
  // still the finished frame when it is copied out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      drop_cnt    <= 8'd0;
    end else begin
      if (pend_q) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= asm_q;
          frame_valid <= 1'b1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resync_cnt <= 8'd0;
      collecting <= 1'b0;
    end else begin
      if (resync_inc && (resync_cnt != 8'hFF)) begin
        resync_cnt <= resync_cnt + 8'd1;
      end
      collecting <= (state_q == COLLECT);
    end
  end

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// tb/tb_mfcc_frame_sequencer.sv - scoreboard bench for mfcc_frame_sequencer
module tb_mfcc_frame_sequencer;

  localparam int NCOEF = 12;
  localparam int W     = 32;
  localparam int FW    = NCOEF * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dv = 1'b0;
  logic [4:0]    x_index = 5'd0;
  logic [W-1:0]  x_i = '0;
  logic          vad = 1'b0;
  logic          frame_ready = 1'b0;
  logic          ng_ready = 1'b1;

  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [7:0]    drop_cnt;
  logic [7:0]    resync_cnt;
  logic          collecting;

  logic          ng_valid;
  logic [FW-1:0] ng_data;
  logic [7:0]    ng_drop;
  logic [7:0]    ng_resync;
  logic          ng_collecting;

  logic [FW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  mfcc_frame_sequencer #(.NCOEF(NCOEF), .W(W), .VAD_GATE(1'b1)) dut (
    .clk(clk), .reset(reset), .dv(dv), .x_index(x_index), .x_i(x_i), .vad(vad),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_data(frame_data),
    .drop_cnt(drop_cnt), .resync_cnt(resync_cnt), .collecting(collecting)
  );

  mfcc_frame_sequencer #(.NCOEF(NCOEF), .W(W), .VAD_GATE(1'b0)) u_ng (
    .clk(clk), .reset(reset), .dv(dv), .x_index(x_index), .x_i(x_i), .vad(vad),
    .frame_ready(ng_ready), .frame_valid(ng_valid), .frame_data(ng_data),
    .drop_cnt(ng_drop), .resync_cnt(ng_resync), .collecting(ng_collecting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [W-1:0] base);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < NCOEF; k++) r[k*W +: W] = base + W'(k);
    return r;
  endfunction

  task automatic cap(input logic [4:0] idx, input logic [W-1:0] val, input logic v);
    x_index = idx;
    x_i     = val;
    vad     = v;
    dv      = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] idx, input logic [W-1:0] val, input logic v);
    cap(idx, val, v);
    idle(1);
  endtask

  task automatic send_frame(input logic [W-1:0] base, input logic [NCOEF-1:0] vmask);
    for (int k = 0; k < NCOEF; k++) send(5'(k), base + W'(k), vmask[k]);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a
  // back-pressured frame does not change while it is held.
  logic [FW-1:0] prev_data = '0;
  logic          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (prev_hold && frame_valid) chk("hold_stable", frame_data, prev_data);
    if (frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%0h required=none", frame_data);
      end else begin
        chk("frame_data", frame_data, exp_q.pop_front());
      end
    end
    prev_hold = frame_valid && !frame_ready;
    prev_data = frame_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", FW'(frame_valid), FW'(0));
    chk("rst_data", frame_data, '0);
    chk("rst_drop", FW'(drop_cnt), FW'(0));
    chk("rst_resync", FW'(resync_cnt), FW'(0));
    chk("rst_collecting", FW'(collecting), FW'(0));
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // Clean voiced frame with an always-ready consumer
    frame_ready = 1'b1;
    exp_q.push_back(mk(32'h100));
    send(5'd0, 32'h100, 1'b1);
    chk("collecting_on", FW'(collecting), FW'(1));
    for (int k = 1; k < NCOEF - 1; k++) send(5'(k), 32'h100 + 32'(k), 1'b1);
    cap(5'd11, 32'h10B, 1'b1);
    chk("latency_not_yet", FW'(frame_valid), FW'(0));
    idle(1);
    chk("latency_valid", FW'(frame_valid), FW'(1));
    idle(1);
    chk("valid_drops", FW'(frame_valid), FW'(0));
    chk("clean_drop", FW'(drop_cnt), FW'(0));
    chk("clean_resync", FW'(resync_cnt), FW'(0));

    // Back-pressure: A held, B dropped, C loads as A is consumed
    frame_ready = 1'b0;
    exp_q.push_back(mk(32'h200));
    send_frame(32'h200, 12'hFFF);
    idle(2);
    chk("bp_held_valid", FW'(frame_valid), FW'(1));
    send_frame(32'h300, 12'hFFF);
    idle(2);
    chk("bp_drop1", FW'(drop_cnt), FW'(1));
    chk("bp_held_data", frame_data, mk(32'h200));
    exp_q.push_back(mk(32'h400));
    for (int k = 0; k < NCOEF - 1; k++) send(5'(k), 32'h400 + 32'(k), 1'b1);
    cap(5'd11, 32'h40B, 1'b1);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    chk("bp_c_valid", FW'(frame_valid), FW'(1));
    chk("bp_c_data", frame_data, mk(32'h400));
    chk("bp_drop_still1", FW'(drop_cnt), FW'(1));
    frame_ready = 1'b1;
    idle(3);
    chk("bp_drained", FW'(frame_valid), FW'(0));

    // Index errors
    send(5'd0, 32'hE0, 1'b1);
    send(5'd1, 32'hE1, 1'b1);
    send(5'd2, 32'hE2, 1'b1);
    send(5'd5, 32'hE5, 1'b1);
    chk("idx_resync1", FW'(resync_cnt), FW'(1));
    chk("idx_back_sync", FW'(collecting), FW'(0));
    send(5'd0, 32'hF0, 1'b1);
    send(5'd1, 32'hF1, 1'b1);
    exp_q.push_back(mk(32'h500));
    send_frame(32'h500, 12'hFFF);
    idle(2);
    chk("idx_resync2", FW'(resync_cnt), FW'(2));
    for (int k = 0; k < 4; k++) send(5'(k), 32'hAB, 1'b1);
    send(5'd20, 32'hAB, 1'b1);
    chk("idx_oob_resync3", FW'(resync_cnt), FW'(3));
    chk("idx_oob_sync", FW'(collecting), FW'(0));

    // VAD gating
    send_frame(32'h700, 12'h000);
    chk("vad0_gated_none", FW'(frame_valid), FW'(0));
    chk("vad0_ungated_valid", FW'(ng_valid), FW'(1));
    chk("vad0_ungated_data", ng_data, mk(32'h700));
    idle(2);
    chk("vad0_drop", FW'(drop_cnt), FW'(1));
    chk("vad0_resync", FW'(resync_cnt), FW'(3));
    exp_q.push_back(mk(32'h800));
    send_frame(32'h800, 12'h040);
    idle(2);

    // dv held high yields one capture; mid-stream start is ignored
    exp_q.push_back(mk(32'h900));
    x_index = 5'd0;
    x_i     = 32'h900;
    vad     = 1'b1;
    dv      = 1'b1;
    idle(5);
    dv = 1'b0;
    idle(1);
    for (int k = 1; k < NCOEF; k++) send(5'(k), 32'h900 + 32'(k), 1'b1);
    idle(2);
    chk("dvhold_resync", FW'(resync_cnt), FW'(3));
    exp_q.push_back(mk(32'hA00));
    for (int k = 7; k < NCOEF; k++) send(5'(k), 32'hDEAD, 1'b1);
    send_frame(32'hA00, 12'hFFF);
    idle(2);
    chk("midstream_resync", FW'(resync_cnt), FW'(3));

    // Asynchronous reset mid-frame
    for (int k = 0; k < 7; k++) send(5'(k), 32'hB00 + 32'(k), 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", FW'(frame_valid), FW'(0));
    chk("rst_mid_data", frame_data, '0);
    chk("rst_mid_drop", FW'(drop_cnt), FW'(0));
    chk("rst_mid_resync", FW'(resync_cnt), FW'(0));
    chk("rst_mid_collecting", FW'(collecting), FW'(0));
    #2 reset = 1'b1;
    idle(1);

    // Asynchronous reset with a frame held
    frame_ready = 1'b0;
    send_frame(32'hC00, 12'hFFF);
    idle(2);
    chk("held_before_rst", FW'(frame_valid), FW'(1));
    #2 reset = 1'b0;
    #1;
    chk("rst_held_valid", FW'(frame_valid), FW'(0));
    chk("rst_held_data", frame_data, '0);
    #2 reset = 1'b1;
    idle(1);
    frame_ready = 1'b1;
    idle(2);
    exp_q.push_back(mk(32'hD00));
    send_frame(32'hD00, 12'hFFF);
    idle(3);
    chk("post_rst_drop", FW'(drop_cnt), FW'(0));
    chk("post_rst_resync", FW'(resync_cnt), FW'(0));
    chk("scoreboard_empty", FW'(exp_q.size()), FW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
